echo_capture: RTL and testbench
===============================

Name: echo_capture

Overview:
- Receive-side counterpart of the pulser trigger.
- Watches the transmit trigger line and, on each rising edge, arms an acquisition window on the ADC sample stream. It measures the time of flight to the first echo whose amplitude reaches a threshold.
- Presents one result per trigger on a valid/ready interface to the downstream display/LED/host logic.
- Sits between the ADC front end and the measurement consumer, in the same 50 MHz clk domain as the trigger generator.

Parameters:
- ADC_W, 8, ADC sample width (unsigned, offset-binary).
- CNT_W, 16, width of the cycle counter and of tof.
- BLANK_CYC, 50, cycles after the trigger edge during which samples are ignored (1 us at 50 MHz; masks transmit bang).
- WIN_CYC, 20000, cycles of the listening window after blanking (400 us).
- SYNC_STAGES, 2, flip-flops in the trig_in synchronizer (>=2).

Ports:
- clk  in  1  50 MHz system clock.
- rst_n  in  1  Reset, asynchronous, active-low.
- trig_in  in  1  Trigger pulse from the pulser; treated as asynchronous.
- adc_data  in  ADC_W  ADC sample.
- adc_valid  in  1  adc_data is valid this cycle.
- threshold  in  ADC_W  Echo detect level; latched at trigger detection.
- echo_valid  out  1  Result available.
- echo_ready  in  1  Consumer accepts the result.
- hit  out  1  1 = threshold crossing found in the window.
- tof  out  CNT_W  Cycles from trigger detection to the first crossing sample.
- busy  out  1  FSM is not in IDLE.
- overrun  out  1  Sticky: a trigger edge arrived while not IDLE.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counter 0, synchronizer cleared, latched threshold 0.
- trig_in passes through SYNC_STAGES flops, then a 1-flop rising-edge detect. A trig_in rise is detected (cycle T0) SYNC_STAGES+1 cycles after it reaches the first flop.
- Counter cnt:
  - Cleared to 0 at T0.
  - Increments every clk cycle in BLANK and WINDOW.
  - Saturates at all-ones; it never wraps.
- FSM:
  - IDLE: on edge -> BLANK; latch threshold; cnt <= 0; clear the hit register.
  - BLANK: when cnt == BLANK_CYC-1 -> WINDOW. No samples are evaluated.
  - WINDOW: on the first cycle with adc_valid && adc_data >= thr_latched, set hit=1 and tof=cnt. Later crossings are ignored. When cnt == BLANK_CYC+WIN_CYC-1 -> REPORT. A crossing on that last cycle counts.
  - REPORT: echo_valid=1. hit and tof are held stable until echo_valid && echo_ready. On that transfer -> IDLE and echo_valid drops the next cycle.
- A window with no crossing reports hit=0, tof=0.
- Trigger edge in BLANK, WINDOW or REPORT: ignored (no restart). overrun is set to 1.
  - overrun is cleared on the cycle a result is accepted, unless another edge arrives in that same cycle; then it stays 1.
- Trigger edge in the same cycle as acceptance in REPORT: ignored (FSM is not yet IDLE) and counted as overrun.
- busy = (state != IDLE).
- threshold changes mid-window have no effect; only the latched value is used.
- adc_valid low cycles are skipped; cnt still advances on them.
- Asserting rst_n low mid-operation aborts immediately to the reset state; no result is reported.
- BLANK_CYC+WIN_CYC must be <= 2^CNT_W-1. This is checked by an elaboration-time assertion.

Optional Feature:
- Macro: ECHO_PEAK_EN.
- Defined: adds outputs peak_amp (ADC_W) and peak_tof (CNT_W).
  - Tracks the maximum adc_data over valid WINDOW samples and the cnt at its first occurrence; ties keep the earlier sample.
  - Both outputs are held with hit/tof in REPORT and reset to 0 at T0.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package echo_pkg holds:
  - State encoding typedef (IDLE, BLANK, WINDOW, REPORT).
  - Default constants FCLK_HZ=50000000, BLANK_CYC, WIN_CYC.
  - The result struct {hit, tof[, peak_amp, peak_tof]}.
- One sub-module: sync_edge_det (SYNC_STAGES synchronizer plus rising-edge pulse). It is reused for other asynchronous inputs.

Test Plan:
(Bench overrides BLANK_CYC=4, WIN_CYC=16, ADC_W=8.)
- Basic hit: threshold=100, trig_in rise, adc_data=120 at cnt=9 only -> echo_valid with hit=1, tof=9; echo_valid stays until echo_ready.
- Blanking: adc_data=255 at cnt=0..3, 0 afterwards -> hit=0, tof=0.
- Boundaries: crossing at cnt=19 -> hit=1, tof=19. Crossing at cnt=20 (sampled in REPORT) -> hit=0.
- Backpressure/overrun:
  - Hold echo_ready=0 and pulse trig_in during REPORT -> overrun=1, outputs unchanged.
  - Then echo_ready=1 -> transfer, overrun=0, back to IDLE; the next trigger is accepted.
- Mid-window changes: threshold changed 100->10 at cnt=6, adc_data=50 -> hit=0. Also adc_valid=0 on a crossing sample -> that sample is not counted.
- Reset mid-WINDOW: rst_n low at cnt=8 -> echo_valid=0, busy=0, overrun=0 immediately. With ECHO_PEAK_EN, samples 30,80,80,40 -> peak_amp=80, peak_tof = cnt of the first 80.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared definitions for the echo capture receive path: FSM state encoding,
// default timing constants and the per-trigger result record.
// Optional feature macro: ECHO_PEAK_EN adds peak amplitude/position to the result.
package echo_pkg;

  // System clock shared with the pulser trigger generator.
  localparam int unsigned FCLK_HZ = 50000000;

  // Default acquisition timing: 1 us blanking, 400 us listening window.
  localparam int unsigned DEF_BLANK_CYC = 50;
  localparam int unsigned DEF_WIN_CYC   = 20000;

  // Default datapath widths; the result record is laid out with these.
  localparam int unsigned DEF_ADC_W = 8;
  localparam int unsigned DEF_CNT_W = 16;

  // Default depth of the trigger synchronizer.
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Acquisition sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    WINDOW = 2'd2,
    REPORT = 2'd3
  } echo_state_t;

  // One measurement result, presented once per accepted trigger.
  typedef struct packed {
    logic                 hit;
    logic [DEF_CNT_W-1:0] tof;
`ifdef ECHO_PEAK_EN
    logic [DEF_ADC_W-1:0] peak_amp;
    logic [DEF_CNT_W-1:0] peak_tof;
`endif
  } echo_result_t;

  // Saturating increment for the time-of-flight counter.
  function automatic logic [DEF_CNT_W-1:0] sat_inc(input logic [DEF_CNT_W-1:0] v);
    sat_inc = (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level input followed by a
// single-flop rising-edge detector. The pulse output is high for exactly one
// clk cycle per synchronized 0->1 transition.
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // A single flop cannot resolve metastability reliably.
  if (STAGES < 2) begin : g_stages_check
    $error("sync_edge_det: STAGES must be at least 2");
  end

  // Shift the raw input through the synchronizer and keep the previous
  // synchronized level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/echo_capture.sv
// Echo capture: arms an acquisition window on each trigger rising edge,
// blanks the transmit bang, then records the cycle count of the first ADC
// sample at or above the latched threshold. One result per trigger is
// offered on a valid/ready interface.
// Optional feature macro: ECHO_PEAK_EN adds peak_amp/peak_tof outputs.
module echo_capture
  import echo_pkg::*;
#(
  parameter int unsigned ADC_W       = DEF_ADC_W,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned BLANK_CYC   = DEF_BLANK_CYC,
  parameter int unsigned WIN_CYC     = DEF_WIN_CYC,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig_in,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] threshold,
  output logic             echo_valid,
  input  logic             echo_ready,
  output logic             hit,
  output logic [CNT_W-1:0] tof,
  output logic             busy,
  output logic             overrun
`ifdef ECHO_PEAK_EN
  ,
  output logic [ADC_W-1:0] peak_amp,
  output logic [CNT_W-1:0] peak_tof
`endif
);

  localparam longint unsigned CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned WIN_LAST = longint'(BLANK_CYC) + longint'(WIN_CYC) - 64'd1;

  // Counter values at which the sequencer leaves BLANK and WINDOW.
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] WIN_END   = CNT_W'(WIN_LAST);

  // Elaboration-time configuration checks.
  if (longint'(BLANK_CYC) + longint'(WIN_CYC) > CNT_MAX) begin : g_range_check
    $error("echo_capture: BLANK_CYC+WIN_CYC exceeds the counter range");
  end
  if (BLANK_CYC < 1 || WIN_CYC < 1) begin : g_nonzero_check
    $error("echo_capture: BLANK_CYC and WIN_CYC must be non-zero");
  end
  if (ADC_W != DEF_ADC_W || CNT_W != DEF_CNT_W) begin : g_width_check
    $error("echo_capture: ADC_W/CNT_W must match the echo_result_t layout");
  end

  echo_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ADC_W-1:0] thr_q;
  echo_result_t     res_q;
  logic             trig_edge;
  logic             crossing;
  logic             accept;

  // Bring the asynchronous trigger into the clk domain and detect its rise.
  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_trig_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (trig_in),
    .pulse (trig_edge)
  );

  assign crossing = adc_valid && (adc_data >= thr_q);
  assign accept   = (state_q == REPORT) && echo_ready;

  // Acquisition sequencer with its counter, latched threshold and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      thr_q      <= '0;
      res_q      <= '0;
      echo_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_edge) begin
            state_q <= BLANK;
            busy    <= 1'b1;
            thr_q   <= threshold;
            cnt_q   <= '0;
            res_q   <= '0;
          end
        end

        BLANK: begin
          cnt_q <= sat_inc(cnt_q);
          if (cnt_q == BLANK_END) begin
            state_q <= WINDOW;
          end
        end

        WINDOW: begin
          cnt_q <= sat_inc(cnt_q);
          // Only the first crossing is recorded; the last window cycle still counts.
          if (crossing && !res_q.hit) begin
            res_q.hit <= 1'b1;
            res_q.tof <= cnt_q;
          end
`ifdef ECHO_PEAK_EN
          // Strictly greater keeps the earliest of equal peaks.
          if (adc_valid && (adc_data > res_q.peak_amp)) begin
            res_q.peak_amp <= adc_data;
            res_q.peak_tof <= cnt_q;
          end
`endif
          if (cnt_q == WIN_END) begin
            state_q    <= REPORT;
            echo_valid <= 1'b1;
          end
        end

        REPORT: begin
          if (echo_ready) begin
            state_q    <= IDLE;
            echo_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end

        default: begin
          state_q    <= IDLE;
          echo_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: set by any trigger edge outside IDLE, cleared on
  // acceptance unless an edge lands in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (trig_edge && (state_q != IDLE)) begin
      overrun <= 1'b1;
    end else if (accept) begin
      overrun <= 1'b0;
    end
  end

  assign hit = res_q.hit;
  assign tof = res_q.tof;
`ifdef ECHO_PEAK_EN
  assign peak_amp = res_q.peak_amp;
  assign peak_tof = res_q.peak_tof;
`endif

endmodule

// File: tb/tb_echo_capture.sv
// Scoreboard bench for echo_capture with short timing (BLANK_CYC=4, WIN_CYC=16).
// Each trial fills a per-cycle sample table indexed by cycles since the
// detected trigger; the reference model scans that table to predict the result.
// Optional feature macro: ECHO_PEAK_EN also checks peak_amp/peak_tof.
module tb_echo_capture;

  localparam int BLANK = 4;
  localparam int WIN   = 16;
  localparam int NCYC  = BLANK + WIN + 2;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig_in;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic [7:0]  threshold;
  logic        echo_valid;
  logic        echo_ready;
  logic        hit;
  logic [15:0] tof;
  logic        busy;
  logic        overrun;
`ifdef ECHO_PEAK_EN
  logic [7:0]  peak_amp;
  logic [15:0] peak_tof;
`endif

  typedef struct {
    bit hit;
    int tof;
    int pamp;
    int ptof;
  } exp_t;

  exp_t q[$];
  int   sdat[NCYC];
  bit   sval[NCYC];
  int   vectors    = 0;
  int   miscompares = 0;

  echo_capture #(
    .ADC_W       (8),
    .CNT_W       (16),
    .BLANK_CYC   (BLANK),
    .WIN_CYC     (WIN),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig_in    (trig_in),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .threshold  (threshold),
    .echo_valid (echo_valid),
    .echo_ready (echo_ready),
    .hit        (hit),
    .tof        (tof),
    .busy       (busy),
    .overrun    (overrun)
`ifdef ECHO_PEAK_EN
    ,
    .peak_amp   (peak_amp),
    .peak_tof   (peak_tof)
`endif
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first valid sample in the listening window at or above the
  // threshold present at trigger time; peak is the earliest maximum.
  function automatic exp_t model(input int thr);
    exp_t e;
    e.hit = 0; e.tof = 0; e.pamp = 0; e.ptof = 0;
    for (int i = BLANK; i < BLANK + WIN; i++) begin
      if (sval[i]) begin
        if (!e.hit && sdat[i] >= thr) begin
          e.hit = 1;
          e.tof = i;
        end
        if (sdat[i] > e.pamp) begin
          e.pamp = sdat[i];
          e.ptof = i;
        end
      end
    end
    return e;
  endfunction

  task automatic clear_samples();
    for (int i = 0; i < NCYC; i++) begin
      sdat[i] = 0;
      sval[i] = 1'b1;
    end
  endtask

  // Monitor: while a result is offered it must match the head of the queue;
  // the entry is retired when the consumer accepts it.
  always @(negedge clk) begin
    if (rst_n && echo_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("hit", hit, q[0].hit);
        chk("tof", tof, q[0].tof);
`ifdef ECHO_PEAK_EN
        chk("peak_amp", peak_amp, q[0].pamp);
        chk("peak_tof", peak_tof, q[0].ptof);
`endif
        if (echo_ready) void'(q.pop_front());
      end
    end
  end

  // One full trigger-to-acceptance transaction using the current sample table.
  task automatic run_trial(input int thr_a, input int thr_b, input int chg_at,
                           input int rw, input bit ovr);
    bit done;
    q.push_back(model(thr_a));
    @(posedge clk); #1;
    threshold = 8'(thr_a);
    trig_in   = 1'b1;
    // Edge is acted on SYNC+1 clocks after the first flop captures trig_in.
    repeat (SYNC + 1) @(posedge clk);
    for (int i = 0; i < NCYC; i++) begin
      #1;
      adc_data  = 8'(sdat[i]);
      adc_valid = sval[i];
      if (i == chg_at) threshold = 8'(thr_b);
      if (i == 0) trig_in = 1'b0;
      @(posedge clk);
    end
    #1;
    adc_data  = '0;
    adc_valid = 1'b0;
    if (ovr) begin
      trig_in = 1'b1;
      repeat (2) @(posedge clk);
      #1 trig_in = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("overrun_set", overrun, 1);
      chk("busy_report", busy, 1);
      chk("valid_held", echo_valid, 1);
    end
    repeat (rw) @(posedge clk);
    @(posedge clk); #1;
    echo_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!echo_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("handshake_done", done, 1);
    echo_ready = 1'b0;
    chk("busy_idle", busy, 0);
    chk("overrun_clear", overrun, 0);
    chk("queue_drained", q.size(), 0);
  endtask

  // Global watchdog so the run always terminates.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    trig_in    = 1'b0;
    adc_data   = '0;
    adc_valid  = 1'b0;
    threshold  = '0;
    echo_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_echo_valid", echo_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_tof", tof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic hit at cnt 9, held under backpressure for a few cycles.
    clear_samples(); sdat[9] = 120;
    run_trial(100, 100, -1, 5, 0);

    // Full-scale bang inside blanking only.
    clear_samples(); for (int i = 0; i < BLANK; i++) sdat[i] = 255;
    run_trial(100, 100, -1, 0, 0);

    // Crossing on the last window cycle counts.
    clear_samples(); sdat[BLANK + WIN - 1] = 200;
    run_trial(100, 100, -1, 1, 0);

    // Crossing one cycle later lands in REPORT and is ignored.
    clear_samples(); sdat[BLANK + WIN] = 200;
    run_trial(100, 100, -1, 1, 0);

    // Trigger during REPORT under backpressure sets overrun; accept clears it.
    clear_samples(); sdat[12] = 150; sdat[14] = 250;
    run_trial(140, 140, -1, 2, 1);

    // Next trigger after the overrun is accepted normally.
    clear_samples(); sdat[5] = 90;
    run_trial(90, 90, -1, 0, 0);

    // Threshold lowered mid-window has no effect.
    clear_samples(); for (int i = 0; i < NCYC; i++) sdat[i] = 50;
    run_trial(100, 10, 6, 0, 0);

    // Crossing sample flagged invalid is skipped; a later valid one counts.
    clear_samples(); sdat[10] = 180; sval[10] = 1'b0; sdat[15] = 101;
    run_trial(100, 100, -1, 0, 0);

    // Peak tracking: 30,80,80,40 below threshold.
    clear_samples(); sdat[6] = 30; sdat[7] = 80; sdat[8] = 80; sdat[9] = 40;
    run_trial(200, 200, -1, 0, 0);

    // Randomized trials.
    for (int t = 0; t < 30; t++) begin
      int thr;
      for (int i = 0; i < NCYC; i++) begin
        sdat[i] = int'($urandom_range(0, 255));
        sval[i] = ($urandom_range(0, 3) != 0);
      end
      thr = int'($urandom_range(0, 255));
      run_trial(thr, int'($urandom_range(0, 255)), int'($urandom_range(1, NCYC - 1)),
                int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset mid-window after an overrun: everything drops immediately.
    clear_samples(); sdat[6] = 200;
    @(posedge clk); #1;
    threshold = 8'd100;
    trig_in   = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    for (int i = 0; i <= 8; i++) begin
      #1;
      adc_data  = 8'(sdat[i]);
      adc_valid = sval[i];
      if (i == 0) trig_in = 1'b0;
      if (i == 1) trig_in = 1'b1;
      if (i == 3) trig_in = 1'b0;
      if (i == 8) begin
        rst_n = 1'b0;
        #1;
        chk("abort_echo_valid", echo_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun, 0);
        chk("abort_hit", hit, 0);
      end else begin
        @(negedge clk);
        if (i == 7) chk("overrun_in_window", overrun, 1);
        @(posedge clk);
      end
    end
    adc_valid = 1'b0;
    adc_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (BLANK + WIN + 4) @(posedge clk);
    @(negedge clk);
    chk("no_report_after_abort", echo_valid, 0);
    chk("idle_after_abort", busy, 0);

    // Sequencer still works after the abort.
    clear_samples(); sdat[11] = 77;
    run_trial(70, 70, -1, 0, 0);

    chk("final_queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
